seven_seg_capture: RTL and testbench
====================================

// Module: seven_seg_capture
// PURPOSE
// Receiving end of the multiplexed 4-digit seven-segment bus (active-low digit selects, active-low pgfedcba segments).
// Samples digit/segment lines, decodes each settled digit, assembles a full thousands->units scan into a binary value.
// Used on test boards to loop back the display driver and in the bench as a self-checking monitor.
// PARAMETERS
// SETTLE_CYCLES  1024     cycles a valid digit select must stay unchanged before its segments are sampled (>=2)
// FRAME_TIMEOUT  1048576  max cycles between consecutive samples inside a frame before the frame is abandoned
// PORTS
// clk           in   1   system clock
// rst_n         in   1   asynchronous reset, active low
// digit         in   4   digit selects, active low; 0111=thousands, 1011=hundreds, 1101=tens, 1110=units
// segments      in   8   segment lines, active low, bit7=dp, bits6..0=gfedcba
// number        out  14  last complete value, 0..9999 binary
// dp_mask       out  4   decimal points of last frame; bit3=thousands .. bit0=units
// number_valid  out  1   one-cycle pulse when number/dp_mask update
// decode_err    out  1   one-cycle pulse: sampled segment pattern is not a digit 0-9
// frame_err     out  1   one-cycle pulse: out-of-order digit or timeout mid-frame
// BEHAVIOUR
// - Reset: number=0, dp_mask=0, number_valid=0, decode_err=0, frame_err=0, FSM=WAIT_D0; sync flops and counters reset to inactive (all ones/zero).
// - digit and segments pass through 2-flop synchronisers; all logic below uses synchronised copies.
// - Valid select = exactly one bit low; else idle (1111 or multiple low): settle counter cleared, no sample.
// - Settle counter: cleared whenever the synced select changes; increments while stable and valid; saturates at SETTLE_CYCLES-1.
// - Sample strobe: single cycle when counter first reaches SETTLE_CYCLES-1 -> exactly one sample per dwell.
// - Decode ~segments[6:0]: 3F=0,06=1,5B=2,4F=3,66=4,6D=5,7D=6,07=7,7F=8,6F=9; any other -> invalid. dp = ~segments[7].
// - FSM states WAIT_D0, WAIT_D1, WAIT_D2, WAIT_D3 (expected position 0..3 = thousands..units):
//   - sample, invalid pattern: decode_err pulse next cycle, -> WAIT_D0, partial digits discarded.
//   - sample at thousands (any state): store digit+dp, -> WAIT_D1 (restart; no error in WAIT_D0/WAIT_D1).
//   - sample at expected position (1..3): store digit+dp, advance; at WAIT_D3 -> WAIT_D0 and complete frame.
//   - sample at any other position: frame_err pulse, -> WAIT_D0 (in WAIT_D0 non-thousands samples are silently ignored).
// - Frame complete: cycle after units sample, number = d0*1000+d1*100+d2*10+d3 and dp_mask registered, number_valid=1 for that cycle.
// - Latency: input edge -> 2 sync cycles + SETTLE_CYCLES dwell -> sample; units sample -> number_valid +1 cycle.
// - Timeout counter: cleared on every sample; in WAIT_D1..D3 reaching FRAME_TIMEOUT -> frame_err pulse, -> WAIT_D0.
// - Thousands restart from WAIT_D2/WAIT_D3 also pulses frame_err (incomplete prior frame).
// - number/dp_mask hold between frames; never updated by aborted frames. Arithmetic max 9999 fits 14 bits.
// - Simultaneous: decode error takes precedence over order check; a sample and timeout in same cycle -> sample wins.
// - Reset mid-frame: all state cleared immediately; the next full frame from thousands is required.
// CONFIGURATION
// SEVEN_SEG_CAPTURE_RAW_EN defined: extra output port digits_bcd [15:0] (out, nibbles d0..d3 msb-first),
//   reset 0, updated in the same cycle as number/number_valid.
// Undefined: port and its registers absent; all other behaviour identical.
// TESTING
// 1. SETTLE_CYCLES=16; scan 1,2,3,4 dwell 64 each, dp on tens -> number=1234 (0x4D2), dp_mask=0010, one number_valid pulse per frame.
// 2. Continuous scan of 9999 for 3 frames -> number=9999 (0x270F), exactly 3 number_valid pulses, no errors.
// 3. Frame 0042 then segments=FF (blank) on hundreds -> decode_err pulse, no number_valid, number stays 42.
// 4. Select glitch to 1101 for 8 cycles (<16) between digits -> no sample, no error, frame 5678 still completes.
// 5. thousands then tens (hundreds skipped) -> frame_err pulse; following good frame 0007 -> number=7.
// 6. rst_n low after two digits of 8888, release, full 0100 frame -> outputs 0 during reset, then number=100; FRAME_TIMEOUT=256 with scan halted after hundreds -> frame_err at 256 cycles.

Source files
------------

// File: rtl/seven_seg_capture.sv
// Receiver for a multiplexed 4-digit active-low seven-segment bus; rebuilds the displayed value.
// Optional SEVEN_SEG_CAPTURE_RAW_EN adds the digits_bcd output.
module seven_seg_capture #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned FRAME_TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  digit,
  input  logic [7:0]  segments,
  output logic [13:0] number,
  output logic [3:0]  dp_mask,
  output logic        number_valid,
  output logic        decode_err,
  output logic        frame_err
`ifdef SEVEN_SEG_CAPTURE_RAW_EN
  ,
  output logic [15:0] digits_bcd
`endif
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES);
  localparam int unsigned TW = $clog2(FRAME_TIMEOUT);

  typedef enum logic [1:0] {WAIT_D0, WAIT_D1, WAIT_D2, WAIT_D3} state_e;

  state_e          state_q, state_d;
  logic [3:0]      dig_s1_q, dig_s2_q, dig_prev_q;
  logic [7:0]      seg_s1_q, seg_s2_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   to_q, to_d;
  logic [2:0][3:0] dig_q, dig_d;
  logic [2:0]      dpb_q, dpb_d;
  logic [13:0]     number_q, number_d;
  logic [3:0]      mask_q, mask_d;
  logic            valid_q, valid_d, dec_q, dec_d, frm_q, frm_d;

  logic            sel_valid, stable, strobe, dec_ok, dp_now, frame_done, bad;
  logic [1:0]      sel_pos;
  logic [3:0]      dec_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_s1_q   <= '1;
      dig_s2_q   <= '1;
      dig_prev_q <= '1;
      seg_s1_q   <= '1;
      seg_s2_q   <= '1;
      cnt_q      <= '0;
      to_q       <= '0;
      state_q    <= WAIT_D0;
      dig_q      <= '0;
      dpb_q      <= '0;
      number_q   <= '0;
      mask_q     <= '0;
      valid_q    <= 1'b0;
      dec_q      <= 1'b0;
      frm_q      <= 1'b0;
    end else begin
      dig_s1_q   <= digit;
      dig_s2_q   <= dig_s1_q;
      dig_prev_q <= dig_s2_q;
      seg_s1_q   <= segments;
      seg_s2_q   <= seg_s1_q;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      state_q    <= state_d;
      dig_q      <= dig_d;
      dpb_q      <= dpb_d;
      number_q   <= number_d;
      mask_q     <= mask_d;
      valid_q    <= valid_d;
      dec_q      <= dec_d;
      frm_q      <= frm_d;
    end
  end

  always_comb begin
    sel_valid = 1'b1;
    sel_pos   = 2'd0;
    case (dig_s2_q)
      4'b0111: sel_pos = 2'd0;
      4'b1011: sel_pos = 2'd1;
      4'b1101: sel_pos = 2'd2;
      4'b1110: sel_pos = 2'd3;
      default: sel_valid = 1'b0;
    endcase
  end

  // Strobe fires on the single cycle the counter steps onto its saturation value.
  always_comb begin
    stable = (dig_s2_q == dig_prev_q);
    strobe = sel_valid && stable && (cnt_q == CW'(SETTLE_CYCLES - 2));
    cnt_d  = cnt_q;
    if (!sel_valid || !stable) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(SETTLE_CYCLES - 1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    dp_now  = ~seg_s2_q[7];
    case (~seg_s2_q[6:0])
      7'h3F: dec_val = 4'd0;
      7'h06: dec_val = 4'd1;
      7'h5B: dec_val = 4'd2;
      7'h4F: dec_val = 4'd3;
      7'h66: dec_val = 4'd4;
      7'h6D: dec_val = 4'd5;
      7'h7D: dec_val = 4'd6;
      7'h07: dec_val = 4'd7;
      7'h7F: dec_val = 4'd8;
      7'h6F: dec_val = 4'd9;
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    dpb_d      = dpb_q;
    number_d   = number_q;
    mask_d     = mask_q;
    valid_d    = 1'b0;
    dec_d      = 1'b0;
    frm_d      = 1'b0;
    frame_done = 1'b0;
    bad        = 1'b0;

    if (strobe) begin
      if (!dec_ok) begin
        dec_d   = 1'b1;
        state_d = WAIT_D0;
      end else if (sel_pos == 2'd0) begin
        dig_d[0] = dec_val;
        dpb_d[0] = dp_now;
        frm_d    = (state_q == WAIT_D2) || (state_q == WAIT_D3);
        state_d  = WAIT_D1;
      end else begin
        case (state_q)
          WAIT_D1: begin
            if (sel_pos == 2'd1) begin
              dig_d[1] = dec_val;
              dpb_d[1] = dp_now;
              state_d  = WAIT_D2;
            end else begin
              bad = 1'b1;
            end
          end
          WAIT_D2: begin
            if (sel_pos == 2'd2) begin
              dig_d[2] = dec_val;
              dpb_d[2] = dp_now;
              state_d  = WAIT_D3;
            end else begin
              bad = 1'b1;
            end
          end
          WAIT_D3: begin
            if (sel_pos == 2'd3) begin
              frame_done = 1'b1;
              state_d    = WAIT_D0;
            end else begin
              bad = 1'b1;
            end
          end
          default: ;
        endcase
        if (bad) begin
          frm_d   = 1'b1;
          state_d = WAIT_D0;
        end
      end
    end else if (state_q != WAIT_D0 && to_q == TW'(FRAME_TIMEOUT - 1)) begin
      frm_d   = 1'b1;
      state_d = WAIT_D0;
    end

    if (frame_done) begin
      number_d = 14'(dig_q[0]) * 14'd1000 + 14'(dig_q[1]) * 14'd100
               + 14'(dig_q[2]) * 14'd10 + 14'(dec_val);
      mask_d   = {dpb_q[0], dpb_q[1], dpb_q[2], dp_now};
      valid_d  = 1'b1;
    end
  end

  always_comb begin
    to_d = to_q;
    if (strobe || state_q == WAIT_D0) begin
      to_d = '0;
    end else if (to_q != TW'(FRAME_TIMEOUT - 1)) begin
      to_d = to_q + 1'b1;
    end
  end

  assign number       = number_q;
  assign dp_mask      = mask_q;
  assign number_valid = valid_q;
  assign decode_err   = dec_q;
  assign frame_err    = frm_q;

`ifdef SEVEN_SEG_CAPTURE_RAW_EN
  logic [15:0] raw_q, raw_d;

  always_comb begin
    raw_d = raw_q;
    if (frame_done) begin
      raw_d = {dig_q[0], dig_q[1], dig_q[2], dec_val};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= '0;
    end else begin
      raw_q <= raw_d;
    end
  end

  assign digits_bcd = raw_q;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: event-level model of digit dwells, per-cycle compare of pulses and held outputs.
module tb_seven_seg_capture;
  localparam int unsigned SETTLE = 16;
  localparam int unsigned FT     = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  digit = 4'hF;
  logic [7:0]  segments = 8'hFF;
  logic [13:0] number;
  logic [3:0]  dp_mask;
  logic        number_valid, decode_err, frame_err;
`ifdef SEVEN_SEG_CAPTURE_RAW_EN
  logic [15:0] digits_bcd;
`endif

  seven_seg_capture #(.SETTLE_CYCLES(SETTLE), .FRAME_TIMEOUT(FT)) dut (
    .clk(clk), .rst_n(rst_n), .digit(digit), .segments(segments),
    .number(number), .dp_mask(dp_mask), .number_valid(number_valid),
    .decode_err(decode_err), .frame_err(frame_err)
`ifdef SEVEN_SEG_CAPTURE_RAW_EN
    , .digits_bcd(digits_bcd)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    int          kind;   // 0 = number_valid, 1 = decode_err, 2 = frame_err
    int          num;
    logic [3:0]  dp;
    logic [15:0] bcd;
  } ev_t;

  ev_t         expq[$];
  int          part_d[$];
  bit          part_dp[$];
  int unsigned mtime = 0;
  int unsigned last_samp = 0;
  int          held_num = 0;
  logic [3:0]  held_dp = '0;
  int          checks = 0, failures = 0;
  int          nval = 0, ndec = 0, nfrm = 0;
  int unsigned last_val_cyc = 0, last_frm_cyc = 0;

  function automatic void check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endfunction

  function automatic int seg2dig(logic [6:0] p);
    for (int i = 0; i < 10; i++) if (PAT[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [7:0] enc(int d, bit dp);
    logic [6:0] p;
    p = PAT[d];
    return ~{dp, p};
  endfunction

  function automatic void push_ev(int kind, int num, logic [3:0] dp, logic [15:0] bcd);
    ev_t e;
    e.kind = kind; e.num = num; e.dp = dp; e.bcd = bcd;
    expq.push_back(e);
  endfunction

  function automatic void clear_part();
    part_d.delete();
    part_dp.delete();
  endfunction

  function automatic void timeout_check(int unsigned t);
    if (part_d.size() > 0 && (t - last_samp) > FT) begin
      push_ev(2, 0, '0, '0);
      clear_part();
    end
  endfunction

  // A dwell of n cycles on a valid select yields one sample; the frame is the sequence of samples.
  function automatic void model_dwell(logic [3:0] sel, logic [7:0] seg, int n);
    int pos, d;
    int unsigned st;
    case (sel)
      4'b0111: pos = 0;
      4'b1011: pos = 1;
      4'b1101: pos = 2;
      4'b1110: pos = 3;
      default: pos = -1;
    endcase
    if (pos >= 0 && n >= int'(SETTLE)) begin
      st = mtime + SETTLE + 1;
      timeout_check(st);
      last_samp = st;
      d = seg2dig(~seg[6:0]);
      if (d < 0) begin
        push_ev(1, 0, '0, '0);
        clear_part();
      end else if (pos == 0) begin
        if (part_d.size() >= 2) push_ev(2, 0, '0, '0);
        clear_part();
        part_d.push_back(d);
        part_dp.push_back(~seg[7]);
      end else if (part_d.size() == 0) begin
        // stray digit outside a frame is ignored
      end else if (pos == part_d.size()) begin
        part_d.push_back(d);
        part_dp.push_back(~seg[7]);
        if (part_d.size() == 4) begin
          push_ev(0, part_d[0] * 1000 + part_d[1] * 100 + part_d[2] * 10 + part_d[3],
                  {part_dp[0], part_dp[1], part_dp[2], part_dp[3]},
                  {4'(part_d[0]), 4'(part_d[1]), 4'(part_d[2]), 4'(part_d[3])});
          clear_part();
        end
      end else begin
        push_ev(2, 0, '0, '0);
        clear_part();
      end
    end
    mtime += n;
    timeout_check(mtime);
  endfunction

  task automatic dwell(logic [3:0] sel, logic [7:0] seg, int n);
    model_dwell(sel, seg, n);
    digit = sel;
    segments = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    dwell(4'hF, 8'hFF, n);
  endtask

  task automatic frame(int a, int b, int c, int d, logic [3:0] dpm);
    dwell(4'b0111, enc(a, dpm[3]), 64);
    dwell(4'b1011, enc(b, dpm[2]), 64);
    dwell(4'b1101, enc(c, dpm[1]), 64);
    dwell(4'b1110, enc(d, dpm[0]), 64);
  endtask

  task automatic do_reset(int n);
    check("pending_before_reset", expq.size(), 0);
    rst_n = 1'b0;
    digit = 4'hF;
    segments = 8'hFF;
    expq.delete();
    clear_part();
    held_num = 0;
    held_dp = '0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mtime += n;
  endtask

  function automatic void expect_ev(int kind, string name);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL %s got=pulse exp=no_event", name);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind) begin
        failures++;
        $display("FAIL %s got_kind=%0d exp_kind=%0d", name, kind, e.kind);
      end else if (kind == 0) begin
        check("valid_number", int'(number), e.num);
        check("valid_dp_mask", int'(dp_mask), int'(e.dp));
`ifdef SEVEN_SEG_CAPTURE_RAW_EN
        check("valid_digits_bcd", int'(digits_bcd), int'(e.bcd));
`endif
        held_num = e.num;
        held_dp = e.dp;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if (number !== 14'd0 || dp_mask !== 4'd0 || number_valid !== 1'b0 ||
          decode_err !== 1'b0 || frame_err !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs got=%0d/%b/%b%b%b exp=0/0000/000",
                 number, dp_mask, number_valid, decode_err, frame_err);
      end
    end else begin
      if (number_valid === 1'b1) begin
        nval++;
        last_val_cyc = cyc;
        expect_ev(0, "number_valid");
      end else begin
        checks++;
        if (number !== 14'(held_num) || dp_mask !== held_dp) begin
          failures++;
          $display("FAIL held_value got=%0d/%b exp=%0d/%b", number, dp_mask, held_num, held_dp);
        end
      end
      if (decode_err === 1'b1) begin
        ndec++;
        expect_ev(1, "decode_err");
      end
      if (frame_err === 1'b1) begin
        nfrm++;
        last_frm_cyc = cyc;
        expect_ev(2, "frame_err");
      end
    end
  end

  initial begin
    int v0, d0, f0;
    int unsigned t;
    do_reset(4);

    // 1: 1234 with dp on tens
    dwell(4'b0111, enc(1, 0), 64);
    dwell(4'b1011, enc(2, 0), 64);
    dwell(4'b1101, enc(3, 1), 64);
    t = cyc;
    dwell(4'b1110, enc(4, 0), 64);
    idle(64);
    check("t1_number", int'(number), 1234);
    check("t1_dp_mask", int'(dp_mask), 2);
    check("t1_valid_pulses", nval, 1);
    check("t1_latency", int'(last_val_cyc - t), 18);
    check("t1_queue_drained", expq.size(), 0);

    // 2: continuous 9999 scan
    v0 = nval; d0 = ndec; f0 = nfrm;
    repeat (3) frame(9, 9, 9, 9, 4'b0000);
    idle(64);
    check("t2_number", int'(number), 16'h270F);
    check("t2_valid_pulses", nval - v0, 3);
    check("t2_errors", (ndec - d0) + (nfrm - f0), 0);

    // 3: 0042 then blank hundreds
    v0 = nval; d0 = ndec;
    frame(0, 0, 4, 2, 4'b0000);
    dwell(4'b0111, enc(0, 0), 64);
    dwell(4'b1011, 8'hFF, 64);
    idle(64);
    check("t3_decode_err", ndec - d0, 1);
    check("t3_valid_pulses", nval - v0, 1);
    check("t3_number", int'(number), 42);

    // 4: short select glitch between digits
    v0 = nval; d0 = ndec; f0 = nfrm;
    dwell(4'b0111, enc(5, 0), 64);
    dwell(4'b1101, enc(0, 0), 8);
    dwell(4'b1011, enc(6, 0), 64);
    dwell(4'b1101, enc(7, 0), 64);
    dwell(4'b1110, enc(8, 0), 64);
    idle(64);
    check("t4_number", int'(number), 5678);
    check("t4_valid_pulses", nval - v0, 1);
    check("t4_errors", (ndec - d0) + (nfrm - f0), 0);

    // 5: hundreds skipped, then 0007
    f0 = nfrm;
    dwell(4'b0111, enc(1, 0), 64);
    dwell(4'b1101, enc(2, 0), 64);
    idle(64);
    check("t5_frame_err", nfrm - f0, 1);
    frame(0, 0, 0, 7, 4'b0000);
    idle(64);
    check("t5_number", int'(number), 7);

    // 6: reset mid-frame, then 0100, then a halted scan
    dwell(4'b0111, enc(8, 0), 64);
    dwell(4'b1011, enc(8, 0), 64);
    do_reset(20);
    check("t6_number_after_reset", int'(number), 0);
    frame(0, 1, 0, 0, 4'b0000);
    idle(64);
    check("t6_number", int'(number), 100);
    f0 = nfrm;
    dwell(4'b0111, enc(1, 0), 64);
    t = cyc;
    dwell(4'b1011, enc(2, 0), 64);
    idle(400);
    check("t6_timeout_err", nfrm - f0, 1);
    check("t6_timeout_latency", int'(last_frm_cyc - t), 2 + SETTLE + FT);
    check("t6_number_kept", int'(number), 100);

    idle(16);
    check("final_queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
